// File: rtl/taxi_axis_route_tag_if.sv
// AXI4-Stream interface bundle shared by the route-tag classifier and its neighbours.
// Unused sideband fields are still present; their *_EN parameters tell consumers whether they carry meaning.
interface taxi_axis_if #(
  parameter int DATA_W  = 8,
  parameter bit KEEP_EN = (DATA_W > 8),
  parameter int KEEP_W  = (DATA_W + 7) / 8,
  parameter bit STRB_EN = 1'b0,
  parameter bit LAST_EN = 1'b1,
  parameter bit ID_EN   = 1'b0,
  parameter int ID_W    = 8,
  parameter bit DEST_EN = 1'b0,
  parameter int DEST_W  = 8,
  parameter bit USER_EN = 1'b0,
  parameter int USER_W  = 1
) ();
  logic [DATA_W-1:0] tdata;
  logic [KEEP_W-1:0] tkeep;
  logic [KEEP_W-1:0] tstrb;
  logic              tvalid;
  logic              tready;
  logic              tlast;
  logic [ID_W-1:0]   tid;
  logic [DEST_W-1:0] tdest;
  logic [USER_W-1:0] tuser;

  modport src (output tdata, tkeep, tstrb, tvalid, tlast, tid, tdest, tuser, input tready);
  modport snk (input tdata, tkeep, tstrb, tvalid, tlast, tid, tdest, tuser, output tready);
endinterface

// File: rtl/taxi_axis_route_tag.sv
// Frame classifier ahead of the AXI4-Stream demux: tags each frame with select/drop/enable.
// Optional frame/drop counters are built when TAXI_AXIS_ROUTE_TAG_STATS_EN is defined.
//
// state | meaning
// IDLE  | next accepted beat is the first beat of a frame
// FRAME | inside a frame; sideband held until the tlast beat
module taxi_axis_route_tag #(
  parameter int M_COUNT      = 4,
  parameter int SEL_OFFSET   = 0,
  parameter int SEL_W        = 8,
  parameter bit DROP_INVALID = 1'b1
) (
  input  logic clk,
  input  logic rst,
  taxi_axis_if.snk s_axis,
  taxi_axis_if.src m_axis,
  input  logic pause,
  input  logic force_drop,
  output logic [(M_COUNT > 1 ? $clog2(M_COUNT) : 1)-1:0] select,
  output logic drop,
  output logic enable,
`ifdef TAXI_AXIS_ROUTE_TAG_STATS_EN
  output logic [31:0] stat_frames,
  output logic [31:0] stat_drops,
`endif
  output logic busy
);

  localparam int SELECT_W = (M_COUNT > 1) ? $clog2(M_COUNT) : 1;
  localparam int DATA_W   = s_axis.DATA_W;
  localparam int KEEP_W   = s_axis.KEEP_W;
  localparam bit LAST_EN  = s_axis.LAST_EN;
  localparam int ID_W     = s_axis.ID_W;
  localparam int DEST_W   = s_axis.DEST_W;
  localparam int USER_W   = s_axis.USER_W;

  if (m_axis.DATA_W != DATA_W || m_axis.KEEP_W != KEEP_W || m_axis.KEEP_EN != s_axis.KEEP_EN ||
      m_axis.STRB_EN != s_axis.STRB_EN || m_axis.LAST_EN != LAST_EN ||
      m_axis.ID_EN != s_axis.ID_EN || m_axis.ID_W != ID_W ||
      m_axis.DEST_EN != s_axis.DEST_EN || m_axis.DEST_W != DEST_W ||
      m_axis.USER_EN != s_axis.USER_EN || m_axis.USER_W != USER_W)
    $fatal(0, "taxi_axis_route_tag: s_axis and m_axis configurations differ");

  if (SEL_OFFSET < 0 || SEL_W < 1 || SEL_OFFSET + SEL_W > DATA_W)
    $fatal(0, "taxi_axis_route_tag: route field does not fit in tdata");

  typedef enum logic [0:0] {IDLE = 1'b0, FRAME = 1'b1} state_t;

  state_t state_reg, state_next;

  logic                tvalid_reg;
  logic [DATA_W-1:0]   tdata_reg;
  logic [KEEP_W-1:0]   tkeep_reg;
  logic [KEEP_W-1:0]   tstrb_reg;
  logic                tlast_reg;
  logic [ID_W-1:0]     tid_reg;
  logic [DEST_W-1:0]   tdest_reg;
  logic [USER_W-1:0]   tuser_reg;
  logic [SELECT_W-1:0] select_reg;
  logic                drop_reg;

  logic                s_ready;
  logic                s_accept;
  logic                s_first;
  logic                s_is_last;
  logic [SEL_W-1:0]    field;
  logic                field_hi;
  logic [31:0]         field_lo;
  logic                field_invalid;
  logic                drop_next;

  // The route field may be wider than 32 bits; any set upper bit is out of range.
  assign field = s_axis.tdata[SEL_OFFSET +: SEL_W];

  if (SEL_W > 32) begin : g_wide_field
    assign field_hi = |field[SEL_W-1:32];
    assign field_lo = field[31:0];
  end else begin : g_narrow_field
    assign field_hi = 1'b0;
    assign field_lo = 32'(field);
  end

  assign field_invalid = field_hi || (field_lo >= 32'(M_COUNT));
  assign drop_next     = force_drop || (DROP_INVALID && field_invalid);

  assign s_ready   = (!tvalid_reg || m_axis.tready) && !(state_reg == IDLE && pause);
  assign s_accept  = s_axis.tvalid && s_ready;
  assign s_is_last = LAST_EN ? s_axis.tlast : 1'b1;
  assign s_first   = s_accept && (state_reg == IDLE);

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (s_accept && !s_is_last) state_next = FRAME;
      FRAME:   if (s_accept && s_is_last) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Sideband only loads with a first beat, which can only enter an empty or draining stage.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg  <= IDLE;
      tvalid_reg <= 1'b0;
      select_reg <= '0;
      drop_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;
      if (s_accept) begin
        tvalid_reg <= 1'b1;
      end else if (m_axis.tready) begin
        tvalid_reg <= 1'b0;
      end
      if (s_first) begin
        select_reg <= SELECT_W'(field);
        drop_reg   <= drop_next;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (s_accept) begin
      tdata_reg <= s_axis.tdata;
      tkeep_reg <= s_axis.tkeep;
      tstrb_reg <= s_axis.tstrb;
      tlast_reg <= s_axis.tlast;
      tid_reg   <= s_axis.tid;
      tdest_reg <= s_axis.tdest;
      tuser_reg <= s_axis.tuser;
    end
  end

`ifdef TAXI_AXIS_ROUTE_TAG_STATS_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      stat_frames <= '0;
      stat_drops  <= '0;
    end else if (s_first) begin
      stat_frames <= stat_frames + 32'd1;
      if (drop_next) stat_drops <= stat_drops + 32'd1;
    end
  end
`endif

  assign s_axis.tready = s_ready;

  assign m_axis.tvalid = tvalid_reg;
  assign m_axis.tdata  = tdata_reg;
  assign m_axis.tkeep  = tkeep_reg;
  assign m_axis.tstrb  = tstrb_reg;
  assign m_axis.tlast  = tlast_reg;
  assign m_axis.tid    = tid_reg;
  assign m_axis.tdest  = tdest_reg;
  assign m_axis.tuser  = tuser_reg;

  assign select = select_reg;
  assign drop   = drop_reg;
  assign enable = tvalid_reg;
  assign busy   = (state_reg == FRAME);

endmodule

// File: tb/tb_taxi_axis_route_tag.sv
// Bench for taxi_axis_route_tag: two instances (DROP_INVALID=1 and 0) fed the same stream,
// each output checked against a queue of expected beats.
module tb_taxi_axis_route_tag;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic pause = 1'b0;
  logic force_drop = 1'b0;
  logic m_ready = 1'b1;
  logic in_valid = 1'b0;
  logic [7:0] in_data = '0;
  logic in_last = 1'b0;
  logic [3:0] in_user = '0;

  always #5 clk = ~clk;

  taxi_axis_if #(.DATA_W(8), .KEEP_EN(1'b0), .LAST_EN(1'b1), .USER_EN(1'b1), .USER_W(4)) s_a (), m_a (), s_b (), m_b ();

  logic [1:0] sel_a, sel_b;
  logic drop_a, drop_b, en_a, en_b, busy_a, busy_b;
`ifdef TAXI_AXIS_ROUTE_TAG_STATS_EN
  logic [31:0] frames_a, drops_a, frames_b, drops_b;
`endif

  assign s_a.tdata = in_data;  assign s_b.tdata = in_data;
  assign s_a.tvalid = in_valid; assign s_b.tvalid = in_valid;
  assign s_a.tlast = in_last;  assign s_b.tlast = in_last;
  assign s_a.tuser = in_user;  assign s_b.tuser = in_user;
  assign s_a.tkeep = '1; assign s_b.tkeep = '1;
  assign s_a.tstrb = '1; assign s_b.tstrb = '1;
  assign s_a.tid = '0;   assign s_b.tid = '0;
  assign s_a.tdest = '0; assign s_b.tdest = '0;
  assign m_a.tready = m_ready;
  assign m_b.tready = m_ready;

  taxi_axis_route_tag #(.M_COUNT(4), .SEL_OFFSET(0), .SEL_W(8), .DROP_INVALID(1'b1)) dut_a (
    .clk(clk), .rst(rst), .s_axis(s_a), .m_axis(m_a), .pause(pause), .force_drop(force_drop),
    .select(sel_a), .drop(drop_a), .enable(en_a),
`ifdef TAXI_AXIS_ROUTE_TAG_STATS_EN
    .stat_frames(frames_a), .stat_drops(drops_a),
`endif
    .busy(busy_a)
  );

  taxi_axis_route_tag #(.M_COUNT(4), .SEL_OFFSET(0), .SEL_W(8), .DROP_INVALID(1'b0)) dut_b (
    .clk(clk), .rst(rst), .s_axis(s_b), .m_axis(m_b), .pause(pause), .force_drop(force_drop),
    .select(sel_b), .drop(drop_b), .enable(en_b),
`ifdef TAXI_AXIS_ROUTE_TAG_STATS_EN
    .stat_frames(frames_b), .stat_drops(drops_b),
`endif
    .busy(busy_b)
  );

  logic       o_valid [2];
  logic       o_ready [2];
  logic [7:0] o_data  [2];
  logic       o_last  [2];
  logic [3:0] o_user  [2];
  logic [1:0] o_sel   [2];
  logic       o_drop  [2];
  logic       o_en    [2];
  logic       i_ready [2];

  assign o_valid[0] = m_a.tvalid; assign o_valid[1] = m_b.tvalid;
  assign o_ready[0] = m_a.tready; assign o_ready[1] = m_b.tready;
  assign o_data[0]  = m_a.tdata;  assign o_data[1]  = m_b.tdata;
  assign o_last[0]  = m_a.tlast;  assign o_last[1]  = m_b.tlast;
  assign o_user[0]  = m_a.tuser;  assign o_user[1]  = m_b.tuser;
  assign o_sel[0]   = sel_a;      assign o_sel[1]   = sel_b;
  assign o_drop[0]  = drop_a;     assign o_drop[1]  = drop_b;
  assign o_en[0]    = en_a;       assign o_en[1]    = en_b;
  assign i_ready[0] = s_a.tready; assign i_ready[1] = s_b.tready;

  typedef struct {
    logic [7:0] data;
    logic       last;
    logic [3:0] user;
    logic [1:0] sel;
    logic       drop;
    int         cyc;
  } exp_t;

  exp_t q [2][$];

  int n_cmp = 0;
  int n_err = 0;
  int cyc = 0;
  int last_pop = 0;
  bit gap_armed = 1'b0;
  bit gap_chk = 1'b0;
  bit lat_chk = 1'b0;
  bit in_frame = 1'b0;
  logic [1:0] cur_sel = '0;
  logic cur_drop [2];
  bit stall [2];
  logic [1:0] hold_sel [2];
  logic hold_drop [2];
  int exp_frames = 0;
  int exp_drops = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Output beats are retired and new input beats predicted on the falling edge.
  always @(negedge clk) begin
    exp_t e;
    cyc++;
    if (rst) begin
      for (int k = 0; k < 2; k++) begin
        q[k].delete();
        stall[k] = 1'b0;
      end
      in_frame = 1'b0;
      gap_armed = 1'b0;
      exp_frames = 0;
      exp_drops = 0;
    end else begin
      for (int k = 0; k < 2; k++) begin
        if (stall[k]) begin
          check($sformatf("sel_hold%0d", k), 32'(o_sel[k]), 32'(hold_sel[k]));
          check($sformatf("drop_hold%0d", k), 32'(o_drop[k]), 32'(hold_drop[k]));
        end
        if (o_valid[k] && o_ready[k]) begin
          if (q[k].size() == 0) begin
            check($sformatf("unexpected_beat%0d", k), 32'd1, 32'd0);
          end else begin
            e = q[k].pop_front();
            check($sformatf("data%0d", k), 32'(o_data[k]), 32'(e.data));
            check($sformatf("last%0d", k), 32'(o_last[k]), 32'(e.last));
            check($sformatf("user%0d", k), 32'(o_user[k]), 32'(e.user));
            check($sformatf("select%0d", k), 32'(o_sel[k]), 32'(e.sel));
            check($sformatf("drop%0d", k), 32'(o_drop[k]), 32'(e.drop));
            check($sformatf("enable%0d", k), 32'(o_en[k]), 32'd1);
            if (lat_chk) check($sformatf("latency%0d", k), 32'(cyc - e.cyc), 32'd1);
          end
          if (k == 0) begin
            if (gap_chk && gap_armed) check("gap", 32'(cyc - last_pop), 32'd1);
            gap_armed = gap_chk;
            last_pop = cyc;
          end
        end
        stall[k] = o_valid[k] && !o_ready[k];
        hold_sel[k] = o_sel[k];
        hold_drop[k] = o_drop[k];
      end
      if (in_valid && i_ready[0]) begin
        if (!in_frame) begin
          cur_sel = in_data[1:0];
          cur_drop[0] = force_drop || (in_data >= 8'd4);
          cur_drop[1] = force_drop;
          exp_frames++;
          if (cur_drop[0]) exp_drops++;
        end
        in_frame = !in_last;
      end
      for (int k = 0; k < 2; k++) begin
        if (in_valid && i_ready[k]) begin
          e.data = in_data;
          e.last = in_last;
          e.user = in_user;
          e.sel = cur_sel;
          e.drop = cur_drop[k];
          e.cyc = cyc;
          q[k].push_back(e);
        end
      end
    end
  end

  task automatic send_beat(input logic [7:0] d, input logic l, input logic fd);
    bit acc = 1'b0;
    int n = 0;
    in_valid = 1'b1;
    in_data = d;
    in_last = l;
    in_user = d[3:0] ^ 4'h5;
    force_drop = fd;
    while (!acc && n < 200) begin
      @(negedge clk);
      acc = i_ready[0];
      @(posedge clk);
      #1;
      n++;
    end
    if (!acc) check("send_timeout", 32'd0, 32'd1);
    in_valid = 1'b0;
    force_drop = 1'b0;
  endtask

  // force_drop is set on the first beat only when fd=1, and on later beats only when fd=0.
  task automatic send_frame(input logic [7:0] d0, input int nb, input logic fd);
    for (int i = 0; i < nb; i++)
      send_beat(d0 + 8'(i * 16), (i == nb - 1), (i == 0) ? fd : !fd);
  endtask

  task automatic drain();
    int n = 0;
    while ((q[0].size() != 0 || q[1].size() != 0 || o_valid[0] || o_valid[1]) && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("drain_timeout", 32'(n < 100), 32'd1);
    check("idle_busy", 32'(busy_a), 32'd0);
    @(posedge clk);
    #1;
  endtask

  logic [3:0] rdy_pat = 4'b1001;

  initial begin
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_tvalid", 32'(o_valid[0]), 32'd0);
    check("rst_select", 32'(sel_a), 32'd0);
    check("rst_drop", 32'(drop_a), 32'd0);
    check("rst_enable", 32'(en_a), 32'd0);
    check("rst_busy", 32'(busy_a), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;

    lat_chk = 1'b1;
    send_frame(8'h02, 4, 1'b0);
    drain();
    send_frame(8'h07, 3, 1'b0);
    drain();

    gap_chk = 1'b1;
    send_beat(8'h01, 1'b1, 1'b0);
    send_beat(8'h03, 1'b1, 1'b0);
    drain();
    gap_chk = 1'b0;
    lat_chk = 1'b0;

    send_beat(8'h21, 1'b0, 1'b0);
    check("mid_busy", 32'(busy_a), 32'd1);
    pause = 1'b1;
    send_beat(8'h22, 1'b0, 1'b0);
    send_beat(8'h23, 1'b1, 1'b0);
    in_valid = 1'b1;
    in_data = 8'h31;
    in_last = 1'b1;
    in_user = 4'h1 ^ 4'h5;
    repeat (4) begin
      @(negedge clk);
      check("pause_tready", 32'(i_ready[0]), 32'd0);
    end
    @(posedge clk);
    #1;
    pause = 1'b0;
    send_beat(8'h31, 1'b1, 1'b0);
    drain();

    fork
      send_frame(8'h42, 4, 1'b0);
      begin
        for (int r = 0; r < 3; r++)
          for (int j = 0; j < 4; j++) begin
            m_ready = rdy_pat[j];
            @(posedge clk);
            #1;
          end
      end
    join
    m_ready = 1'b1;
    drain();

    send_frame(8'h01, 2, 1'b1);
    drain();
    send_frame(8'h06, 2, 1'b0);
    drain();

`ifdef TAXI_AXIS_ROUTE_TAG_STATS_EN
    check("stat_frames", frames_a, 32'(exp_frames));
    check("stat_drops", drops_a, 32'(exp_drops));
    check("stat_frames_b", frames_b, 32'(exp_frames));
`endif

    send_beat(8'h02, 1'b0, 1'b0);
    send_beat(8'h12, 1'b0, 1'b0);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("midrst_tvalid", 32'(o_valid[0]), 32'd0);
    check("midrst_select", 32'(sel_a), 32'd0);
    check("midrst_drop", 32'(drop_a), 32'd0);
    check("midrst_enable", 32'(en_a), 32'd0);
    check("midrst_busy", 32'(busy_a), 32'd0);
`ifdef TAXI_AXIS_ROUTE_TAG_STATS_EN
    check("midrst_frames", frames_a, 32'd0);
`endif
    rst = 1'b0;
    @(posedge clk);
    #1;
    send_frame(8'h01, 2, 1'b0);
    drain();
`ifdef TAXI_AXIS_ROUTE_TAG_STATS_EN
    check("post_rst_frames", frames_a, 32'd1);
    check("post_rst_drops", drops_a, 32'd0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
